ks_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider; the inverse-operation companion to the

---
 rtl/ks_arith_pkg.sv | 22 ++
 rtl/ks_subtractor.sv | 45 ++++
 rtl/ks_restoring_divider.sv | 118 +++++++++++
 tb/tb_ks_restoring_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ks_arith_pkg.sv
// Shared types and helpers for the ks arithmetic blocks.
// Holds the divider FSM state type and a constant clog2.
package ks_arith_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ks_subtractor.sv
// Kogge-Stone parallel-prefix adder used as a - b (a + ~b + cin).
// cout=1 means no borrow, i.e. a >= b when cin=1.
module ks_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] gk;
  logic [WIDTH-1:0] pk;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] pn;
  logic [WIDTH-1:0] carry;

  // Bitwise propagate/generate, cin folded into bit 0, then log2 prefix stages
  always_comb begin
    p = a ^ ~b;
    g = a & ~b;
    gk = g;
    pk = p;
    gk[0] = g[0] | (p[0] & cin);
    gn = gk;
    pn = pk;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      gn = gk;
      pn = pk;
      for (int i = s; i < WIDTH; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-s]);
        pn[i] = pk[i] & pk[i-s];
      end
      gk = gn;
      pk = pn;
    end
    carry = {gk[WIDTH-2:0], cin};
    diff = p ^ carry;
    cout = gk[WIDTH-1];
  end

endmodule

// File: rtl/ks_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Trial subtraction goes through a Kogge-Stone subtractor.
module ks_restoring_divider
  import ks_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t state;
  div_state_t state_nxt;

  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             cout;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             accept;
  logic             zero_dvs;
  logic             last;

  assign shifted  = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign rem_nxt  = cout ? diff : shifted;
  assign q_nxt    = {q_r[WIDTH-2:0], cout};
  assign accept   = start && (state != BUSY);
  assign zero_dvs = (divisor == '0);
  assign last     = (state == BUSY) && (count == LAST);

  ks_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a   (shifted),
    .b   ({1'b0, dvs_r}),
    .cin (1'b1),
    .diff(diff),
    .cout(cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = zero_dvs ? DONE : BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = zero_dvs ? DONE : BUSY;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift iterations and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_dvs) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_r <= '0;
        q_r   <= dividend;
        dvs_r <= divisor;
        count <= '0;
      end
    end else if (state == BUSY) begin
      rem_r <= rem_nxt;
      q_r   <= q_nxt;
      count <= count + 1'b1;
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= rem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ks_restoring_divider.sv
// Self-checking bench for ks_restoring_divider (WIDTH=4).
// Expected results queue on issue and are popped on each done pulse.
module tb_ks_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  ks_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = W'(a);
      e.dz = 1'b1;
    end else begin
      e.q = W'(a / b);
      e.r = W'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
      end
    end
  end

  task automatic issue(input int a, input int b, input bit push);
    dividend = W'(a);
    divisor = W'(b);
    start = 1'b1;
    if (push) sb.push_back(model(a, b));
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output int nb);
    lat = 0;
    nb = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) break;
      if (lat >= limit) begin
        check("timeout", 0, 1);
        break;
      end
    end
  endtask

  int lat;
  int nb;
  int base;
  int pa;
  int pb;
  int corners[4][2] = '{'{15, 1}, '{3, 7}, '{15, 15}, '{0, 5}};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    rst = 1'b0;

    @(negedge clk);
    issue(13, 4, 1);
    accept_edge();
    wait_done(20, lat, nb);
    check("basic_lat", lat, 5);
    check("basic_busy", nb, 4);
    repeat (3) @(negedge clk);
    check("hold_q", quotient, 3);
    check("hold_r", remainder, 1);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(corners[i][0], corners[i][1], 1);
      accept_edge();
      wait_done(20, lat, nb);
      check("corner_lat", lat, 5);
    end

    @(negedge clk);
    issue(9, 0, 1);
    accept_edge();
    wait_done(20, lat, nb);
    check("dz_lat", lat, 1);
    check("dz_busy", nb, 0);

    @(negedge clk);
    base = done_cnt;
    issue(13, 4, 1);
    accept_edge();
    @(negedge clk);
    @(negedge clk);
    issue(6, 2, 0);
    accept_edge();
    repeat (10) @(negedge clk);
    check("busy_ndone", done_cnt - base, 1);
    check("busy_q", quotient, 3);
    check("busy_r", remainder, 1);

    base = done_cnt;
    issue(14, 3, 0);
    accept_edge();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dz", div_by_zero, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rst_ndone", done_cnt - base, 0);
    issue(14, 3, 1);
    accept_edge();
    wait_done(20, lat, nb);
    check("after_rst_lat", lat, 5);

    @(negedge clk);
    @(negedge clk);
    pa = 0;
    pb = 0;
    issue(pa, pb, 1);
    for (int k = 1; k <= 256; k++) begin
      wait_done(20, lat, nb);
      check("b2b_lat", lat, (pb == 0) ? 1 : 5);
      if (k < 256) begin
        pa = k >> 4;
        pb = k & 15;
        issue(pa, pb, 1);
      end else begin
        start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
